mac_pipe: RTL

Parametrised, pipelined multiply-accumulate unit; successor to the fixed 16x16/36-bit MAC.
- Accumulates LEN products per frame, then presents the frame result with a one-cycle valid pulse and restarts at zero with no bubble.
- Adds a per-term signed/unsigned mode, synchronous clear, a sticky overflow flag and a valid-qualified input.
- Sits in the datapath feeding dot-product / filter results to downstream logic.

---
 rtl/mac_pkg.sv | 29 ++
 rtl/mac_mult_stage.sv | 46 ++++
 rtl/mac_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the pipelined multiply-accumulate unit.
// Optional build macro MAC_SAT_EN (see mac_pipe) does not affect this package.
package mac_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 36;
    localparam int DEF_LEN    = 12;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Widest accumulator the extension helper can serve.
    localparam int EXT_MAX_W   = 128;
    localparam int EXT_IDX_W   = 7;

    // Sign- or zero-extend the low prod_w bits of prod to EXT_MAX_W bits.
    function automatic logic [EXT_MAX_W-1:0] ext_prod(
        input logic [EXT_MAX_W-1:0] prod,
        input int                   prod_w,
        input logic                 mode
    );
        logic [EXT_MAX_W-1:0] mask;
        logic                 fill;
        mask = ~({EXT_MAX_W{1'b1}} << prod_w);
        fill = (mode == MODE_SIGNED) && prod[EXT_IDX_W'(prod_w - 1)];
        return fill ? (prod | ~mask) : (prod & mask);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Stage 1 of mac_pipe: registered signed/unsigned multiplier with valid and
// mode pass-through. A clear in the same cycle drops the incoming term.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_signed,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  p_valid,
    output logic                  p_mode,
    output logic [2*DATA_W-1:0]   p_prod
);

    logic [2*DATA_W-1:0] ax;
    logic [2*DATA_W-1:0] bx;
    logic [2*DATA_W-1:0] prod_n;
    logic                take;

    // Extending both operands to the product width makes the low 2*DATA_W
    // bits of a plain multiply correct for either signedness.
    assign ax     = {{DATA_W{in_signed & a[DATA_W-1]}}, a};
    assign bx     = {{DATA_W{in_signed & b[DATA_W-1]}}, b};
    assign prod_n = ax * bx;
    assign take   = in_valid & ~clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_valid <= 1'b0;
            p_mode  <= MODE_UNSIGNED;
            p_prod  <= '0;
        end else begin
            p_valid <= take;
            if (take) begin
                p_prod <= prod_n;
                p_mode <= in_signed;
            end
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate: LEN products per frame, one-cycle result pulse.
// Build macro MAC_SAT_EN: clamp the sum on overflow instead of wrapping.
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_signed,
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic                 clear,
    output logic [ACC_W-1:0]     acc,
    output logic [ACC_W-1:0]     result,
    output logic                 out_valid,
    output logic                 overflow
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic                 p_valid;
    logic                 p_mode;
    logic [2*DATA_W-1:0]  p_prod;
    logic [ACC_W-1:0]     ext;
    logic [ACC_W:0]       sum_wide;
    logic [ACC_W-1:0]     sum_raw;
    logic [ACC_W-1:0]     sum_next;
    logic                 s_ovf;
    logic                 ovf_now;
    logic [CNT_W-1:0]     count;

    mac_mult_stage #(.DATA_W(DATA_W)) u_mult (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_signed (in_signed),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .p_valid   (p_valid),
        .p_mode    (p_mode),
        .p_prod    (p_prod)
    );

    assign ext      = ACC_W'(ext_prod(EXT_MAX_W'(p_prod), 2 * DATA_W, p_mode));
    assign sum_wide = {1'b0, acc} + {1'b0, ext};
    assign sum_raw  = sum_wide[ACC_W-1:0];
    assign s_ovf    = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
    assign ovf_now  = (p_mode == MODE_SIGNED) ? s_ovf : sum_wide[ACC_W];

`ifdef MAC_SAT_EN
    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    // A signed overflow only happens when acc and product share a sign,
    // so the product sign picks the rail.
    always_comb begin
        sum_next = sum_raw;
        if (ovf_now) begin
            if (p_mode == MODE_SIGNED)
                sum_next = ext[ACC_W-1] ? MIN_NEG : MAX_POS;
            else
                sum_next = '1;
        end
    end
`else
    assign sum_next = sum_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (p_valid) begin
                if (ovf_now)
                    overflow <= 1'b1;
                if (count == CNT_W'(LEN - 1)) begin
                    result    <= sum_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                end else begin
                    acc   <= sum_next;
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule
